// File: rtl/snn_image_tx_if.sv
// snn_image_tx_if: control, pixel-memory and UART byte handshake signals of the image streamer.
// master = streamer side, slave = environment side (pixel RAM, UART, host control).
interface snn_image_tx_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_q;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_rdy;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic [3:0]        digit;
    logic              err;

    modport master (
        input  start, pix_q, tx_rdy, rx_rdy, rx_data,
        output busy, done, pix_addr, tx_start, tx_data, digit, err
    );

    modport slave (
        output start, pix_q, tx_rdy, rx_rdy, rx_data,
        input  busy, done, pix_addr, tx_start, tx_data, digit, err
    );
endinterface

// File: rtl/snn_image_tx.sv
// snn_image_tx: streams a 1-bit image from a synchronous-read pixel memory as
// LSB-first packed bytes over a UART byte handshake, then captures the classifier's
// single result byte.
// Optional feature macro: SNN_RX_TIMEOUT_EN (result wait gives up after TIMEOUT_CYCLES).
module snn_image_tx #(
    parameter int unsigned NUM_PIXELS     = 784,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    snn_image_tx_if.master bus
);
    localparam int unsigned NUM_BYTES = NUM_PIXELS / 8;
    localparam int unsigned BCNT_W    = $clog2(NUM_BYTES + 1);
    localparam int unsigned FCNT_W    = 4;

    typedef enum logic [2:0] {
        IDLE, FETCH, SEND, WAIT_LO, WAIT_HI, RESULT, FIN
    } state_t;

    state_t            state;
    logic [BCNT_W-1:0] byte_cnt;
    logic [FCNT_W-1:0] fcnt;
    logic [7:0]        sr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pix_addr;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [3:0]        digit;
    logic              err;

`ifdef SNN_RX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tcnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Sequencer: fetch 8 pixels, send byte, wait for UART, repeat; then await result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            pix_addr <= '0;
            digit    <= 4'h0;
            err      <= 1'b0;
            byte_cnt <= '0;
            fcnt     <= '0;
            sr       <= 8'h00;
`ifdef SNN_RX_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            done     <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        byte_cnt <= '0;
                        pix_addr <= '0;
                        fcnt     <= '0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // read data lags the address by one cycle, so capture runs cycles 1..8
                    if (fcnt != FCNT_W'(0)) begin
                        sr <= {bus.pix_q, sr[7:1]};
                    end
                    if (fcnt < FCNT_W'(7)) begin
                        pix_addr <= pix_addr + ADDR_W'(1);
                    end
                    if (fcnt == FCNT_W'(8)) begin
                        fcnt  <= '0;
                        state <= SEND;
                    end else begin
                        fcnt <= fcnt + FCNT_W'(1);
                    end
                end
                SEND: begin
                    if (bus.tx_rdy) begin
                        tx_start <= 1'b1;
                        tx_data  <= sr;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_rdy) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (bus.tx_rdy) begin
                        byte_cnt <= byte_cnt + BCNT_W'(1);
                        if (byte_cnt == BCNT_W'(NUM_BYTES - 1)) begin
                            state <= RESULT;
`ifdef SNN_RX_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            // address stops at the last pixel; it only advances between bytes
                            pix_addr <= pix_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end
                    end
                end
                RESULT: begin
                    if (bus.rx_rdy) begin
                        digit <= bus.rx_data[3:0];
                        err   <= (bus.rx_data > 8'd9);
                        done  <= 1'b1;
                        state <= FIN;
                    end
`ifdef SNN_RX_TIMEOUT_EN
                    else if (tcnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        digit <= 4'hF;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + TMO_W'(1);
                    end
`endif
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pix_addr = pix_addr;
    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data;
    assign bus.digit    = digit;
    assign bus.err      = err;
endmodule

// File: tb/tb_snn_image_tx.sv
// tb_snn_image_tx: directed image streams against a bench pixel RAM and UART model;
// expected bytes come from packing the bench image array.
module tb_snn_image_tx;
    localparam int unsigned NUM_PIXELS = 784;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned NUM_BYTES  = NUM_PIXELS / 8;
    localparam int unsigned TMO        = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_image_tx_if #(.ADDR_W(ADDR_W)) bus ();

    snn_image_tx #(
        .NUM_PIXELS(NUM_PIXELS),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic       img    [NUM_PIXELS];
    logic [7:0] rx_log [NUM_BYTES];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         sent     = 0;
    int         img_base = 0;
    int         uart_cnt = 0;
    bit         hold     = 1'b0;
    logic [7:0] hold_val = 8'h00;

    // synchronous-read pixel memory
    always @(posedge clk) bus.pix_q <= img[bus.pix_addr];

    function automatic logic [7:0] model_byte(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = img[8*b + i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // compare process + UART model: check each loaded byte, then emulate transmit time
    always @(negedge clk) begin
        int idx;
        if (rst) begin
            uart_cnt   = 0;
            bus.tx_rdy = ~hold;
        end else begin
            if (bus.tx_start) begin
                idx = sent - img_base;
                chk("tx_rdy_at_tx_start", 32'(bus.tx_rdy), 32'd1);
                if (idx < int'(NUM_BYTES)) begin
                    chk($sformatf("tx_byte[%0d]", idx), 32'(bus.tx_data), 32'(model_byte(idx)));
                    rx_log[idx] = bus.tx_data;
                end else begin
                    chk("tx_start_count", 32'(idx), 32'(NUM_BYTES - 1));
                end
                sent++;
                bus.tx_rdy = 1'b0;
                uart_cnt   = 10;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) bus.tx_rdy = ~hold;
            end else begin
                bus.tx_rdy = ~hold;
            end
            if (hold) chk("tx_data_stable", 32'(bus.tx_data), 32'(hold_val));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        int budget = 6000;
        while ((sent - img_base) < n && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) bound_fail($sformatf("wait_sent_%0d", n));
    endtask

    // returns on the cycle tx_rdy comes back after the last byte (final WAIT_HI exit next edge)
    task automatic wait_image_sent();
        int budget = 50;
        wait_sent(NUM_BYTES);
        while (!bus.tx_rdy && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) bound_fail("wait_last_tx_rdy");
    endtask

    task automatic finish_result(input logic [7:0] rdata, input logic [3:0] exp_digit,
                                 input logic exp_err, input logic [3:0] pre_digit);
        wait_image_sent();
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h05;
        tick();
        bus.rx_rdy  = 1'b0;
        chk("done_after_early_rx", 32'(bus.done), 32'd0);
        chk("digit_after_early_rx", 32'(bus.digit), 32'(pre_digit));
        bus.rx_rdy  = 1'b1;
        bus.rx_data = rdata;
        tick();
        bus.rx_rdy  = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("digit", 32'(bus.digit), 32'(exp_digit));
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("busy_during_done", 32'(bus.busy), 32'd1);
        tick();
        chk("done_cleared", 32'(bus.done), 32'd0);
        chk("busy_dropped", 32'(bus.busy), 32'd0);
        chk("tx_start_total", 32'(sent - img_base), 32'(NUM_BYTES));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_pix_addr"}, 32'(bus.pix_addr), 32'd0);
        chk({tag, "_digit"}, 32'(bus.digit), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic clear_img();
        for (int i = 0; i < int'(NUM_PIXELS); i++) img[i] = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        clear_img();
        rst = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // image A: all zero, first-byte latency
        chk("model_zero_byte", 32'(model_byte(0)), 32'h00);
        img_base = sent;
        pulse_start();
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("pix_addr_fetch0", 32'(bus.pix_addr), 32'd0);
        repeat (9) tick();
        chk("no_tx_start_before_t10", 32'(bus.tx_start), 32'd0);
        tick();
        chk("first_tx_start_t10", 32'(bus.tx_start), 32'd1);
        finish_result(8'h07, 4'h7, 1'b0, 4'h0);

        // image B: alternating pixels, stray rx_rdy and start while busy
        for (int i = 0; i < int'(NUM_PIXELS); i++) img[i] = 1'(i % 2);
        chk("model_alt_byte", 32'(model_byte(5)), 32'hAA);
        img_base = sent;
        pulse_start();
        wait_sent(10);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h03;
        tick();
        bus.rx_rdy  = 1'b0;
        chk("digit_after_stray_rx", 32'(bus.digit), 32'h7);
        wait_sent(20);
        pulse_start();
        finish_result(8'h0C, 4'hC, 1'b1, 4'h7);
        chk("alt_last_byte", 32'(rx_log[NUM_BYTES-1]), 32'hAA);
        chk("pix_addr_last", 32'(bus.pix_addr), 32'(NUM_PIXELS - 1));
        repeat (30) tick();
        chk("ignored_start_idle", 32'(bus.busy), 32'd0);
        chk("ignored_start_count", 32'(sent - img_base), 32'(NUM_BYTES));

        // image C: pixel 0 only, transmitter held busy before byte 0
        clear_img();
        img[0] = 1'b1;
        chk("model_pix0_byte", 32'(model_byte(0)), 32'h01);
        chk("tx_data_held_prev", 32'(bus.tx_data), 32'hAA);
        hold_val = bus.tx_data;
        hold     = 1'b1;
        img_base = sent;
        pulse_start();
        repeat (500) tick();
        chk("no_tx_while_held", 32'(sent - img_base), 32'd0);
        hold = 1'b0;
        finish_result(8'h09, 4'h9, 1'b0, 4'hC);
        chk("pix0_byte0", 32'(rx_log[0]), 32'h01);
        chk("pix0_byte1", 32'(rx_log[1]), 32'h00);

        // image D: pixel 783 only, reset during byte 50 then resend
        clear_img();
        img[NUM_PIXELS-1] = 1'b1;
        chk("model_last_byte", 32'(model_byte(NUM_BYTES-1)), 32'h80);
        img_base = sent;
        pulse_start();
        wait_sent(50);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset_values("midreset");
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("idle_after_reset_busy", 32'(bus.busy), 32'd0);
        chk("no_tx_after_reset", 32'(sent - img_base), 32'd50);
        img_base = sent;
        pulse_start();
        finish_result(8'h0A, 4'hA, 1'b1, 4'h0);
        chk("last_pix_byte97", 32'(rx_log[NUM_BYTES-1]), 32'h80);
        chk("last_pix_byte0", 32'(rx_log[0]), 32'h00);

`ifdef SNN_RX_TIMEOUT_EN
        // image E: no result byte, expect timeout
        clear_img();
        img_base = sent;
        pulse_start();
        wait_image_sent();
        repeat (100) tick();
        chk("tmo_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("tmo_done", 32'(bus.done), 32'd1);
        chk("tmo_digit", 32'(bus.digit), 32'hF);
        chk("tmo_err", 32'(bus.err), 32'd1);
        tick();
        chk("tmo_busy_dropped", 32'(bus.busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/snn_image_tx.md
# snn_image_tx

Host-side image streamer for the SNN digit classifier: reads a 784-pixel, 1-bit image from a synchronous-read bit memory and packs it LSB-first into 98 bytes. It sends them through a byte-level UART transmitter handshake, then waits for the single result byte returned by the classifier. It is the sending end of the classifier's image-load UART link and drives FPGA-to-FPGA and bench-level image injection.

## Interface
- NUM_PIXELS, 784: pixels per image; must be a multiple of 8; NUM_BYTES = NUM_PIXELS/8 (98)
- ADDR_W, 10: pixel address width
- TIMEOUT_CYCLES, 1000000: result-wait limit (used only with SNN_RX_TIMEOUT_EN)

- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; synchronous and active-high
- start  in  1  begin sending one image; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when result captured (or on timeout)
- pix_addr  out  ADDR_W  pixel memory read address
- pix_q  in  1  pixel data, valid the cycle after pix_addr
- tx_start  out  1  one-cycle pulse; loads tx_data into the UART transmitter
- tx_data  out  8  byte to transmit; held stable from tx_start until the next load
- tx_rdy  in  1  transmitter idle
- rx_rdy  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- digit  out  4  classified digit, held until the next result
- err  out  1  result byte out of range (>9) or timeout; held with digit

## Operation
- Reset values: busy=0, done=0, tx_start=0, tx_data=0x00, pix_addr=0, digit=0, err=0; state IDLE. Reset mid-image aborts immediately with no further tx_start, and the next start sends from pixel 0.
- States: IDLE, FETCH, SEND, WAIT_LO, WAIT_HI, RESULT, FIN.
- IDLE: on start, clear the byte counter and pixel address, then go to FETCH. start in any other state is ignored.
- FETCH: 9 cycles per byte. In cycles 0..7, pix_addr = 8*byte + cycle. In cycles 1..8, capture pix_q into shift register sr = {pix_q, sr[7:1]}. After cycle 8, bit i of the byte = pixel 8*byte + i. Then go to SEND.
- SEND: wait for tx_rdy=1. Then pulse tx_start, set tx_data=sr, and go to WAIT_LO.
- WAIT_LO: wait for tx_rdy=0, then go to WAIT_HI.
- WAIT_HI: wait for tx_rdy=1. Then increment the byte counter. If the counter reaches NUM_BYTES, go to RESULT; otherwise go to FETCH.
- RESULT: on rx_rdy, set digit=rx_data[3:0] and err=(rx_data>9), then go to FIN. rx_rdy in any other state is discarded.
- FIN: pulse done, drop busy, and return to IDLE.
- Byte counter width: ceil(log2(NUM_BYTES+1)) bits. Pixel address does not wrap within an image; its last value is NUM_PIXELS-1.

## Timing
- start high at edge t → busy=1 and FETCH cycle 0 (pix_addr=0) at t+1. The first tx_start is at t+10 if tx_rdy=1.
- Per byte: 9 FETCH cycles, plus at least 1 SEND cycle, plus transmitter busy time, plus 1 cycle. No overlap of fetch with transmit.
- tx_start never asserts while tx_rdy=0. Exactly NUM_BYTES pulses occur per image.
- rx_rdy at edge r in RESULT → digit/err update and done=1 in cycle r+1. busy=0 from r+2.
- An rx_rdy pulse in the same cycle as the final WAIT_HI exit is discarded; the result must arrive while in RESULT.

## Configuration
- SNN_RX_TIMEOUT_EN defined: RESULT counts cycles. After TIMEOUT_CYCLES cycles without rx_rdy, set digit=4'hF and err=1, pulse done, and return to IDLE. The counter clears on entry to RESULT.
- Not defined: RESULT waits indefinitely, and no timeout counter is synthesised.

## Test plan
- All-zero image, bench UART model (tx_rdy low 1 cycle after tx_start, high 10 cycles later) → 98 tx_start pulses, all tx_data=0x00; first pulse at start+10.
- Pixel[i]=i%2 → every byte 0xAA. Pixel[0]=1 only → byte 0 = 0x01, bytes 1..97 = 0x00. Pixel[783]=1 only → byte 97 = 0x80.
- After the last byte, rx_rdy with rx_data=0x07 → digit=7, err=0, done pulses the next cycle. With rx_data=0x0C → digit=0xC, err=1.
- rst asserted during byte 50 → all outputs take reset values the next cycle with no tx_start. A new start sends 98 bytes from pixel 0. start while busy → ignored, byte count unchanged.
- tx_rdy held low 500 cycles before byte 0 → no tx_start until tx_rdy=1, and tx_data is stable. An rx_rdy pulse during transmission → discarded, digit unchanged.
- SNN_RX_TIMEOUT_EN with TIMEOUT_CYCLES=100 and no rx_rdy → done 100 cycles after RESULT entry, digit=0xF, err=1.
